// File: rtl/imhotep_pkg.sv
// Shared core definitions: register-file geometry and issue-control types.
package imhotep_pkg;

  localparam int unsigned RFADDR    = 5;
  localparam int unsigned NREGS     = 1 << RFADDR;
  localparam int unsigned MAX_LOADS = 2;
  localparam int unsigned LDCNT_W   = $clog2(MAX_LOADS + 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WAIT_BR = 2'd1,
    HALT    = 2'd2
  } issue_state_e;

endpackage

// File: rtl/issue_ctrl_scoreboard.sv
// Register busy scoreboard for in-flight loads plus the load-use hazard lookup.
module reg_scoreboard #(
  parameter int unsigned RFADDR    = 5,
  parameter int unsigned MAX_LOADS = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       set_i,
  input  logic [RFADDR-1:0]          set_addr_i,
  input  logic                       clr_i,
  input  logic [RFADDR-1:0]          clr_addr_i,
  input  logic [RFADDR-1:0]          r1_addr_i,
  input  logic [RFADDR-1:0]          r2_addr_i,
  input  logic [RFADDR-1:0]          rd_addr_i,
  input  logic                       is_load_i,
  output logic                       hazard_o,
  output logic [(1 << RFADDR)-1:0]   busy_o
);

  localparam int unsigned NREG  = 1 << RFADDR;
  localparam int unsigned CNT_W = $clog2(MAX_LOADS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOADS);

  logic [NREG-1:0]  r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic             r_armed;

  logic [NREG-1:0]  w_busy_nxt;
  logic             w_set;
  logic             w_clr;
  logic             w_src_busy;

  // x0 is never tracked; a writeback with nothing in flight is a stale one from before reset
  assign w_set = set_i & (set_addr_i != '0);
  assign w_clr = clr_i & (r_cnt != '0);

  // Next busy vector: clear first so a same-register set wins
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_clr) w_busy_nxt[clr_addr_i] = 1'b0;
    if (w_set) w_busy_nxt[set_addr_i] = 1'b1;
  end

  // Busy vector and in-flight load counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_busy  <= '0;
      r_cnt   <= '0;
      r_armed <= 1'b0;
    end else begin
      r_busy  <= w_busy_nxt;
      r_armed <= r_armed | w_set;
      case ({w_set, w_clr})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Once a load has issued since reset, every writeback must match an in-flight load
  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(clr_i && r_armed && (r_cnt == '0)))
    else $error("reg_scoreboard: load count underflow");

  // Source/destination busy lookup against registered state (no bypass)
  always_comb begin
    w_src_busy = ((r1_addr_i != '0) && r_busy[r1_addr_i]) ||
                 ((r2_addr_i != '0) && r_busy[r2_addr_i]) ||
                 ((rd_addr_i != '0) && r_busy[rd_addr_i]);
    hazard_o   = w_src_busy || (is_load_i && (r_cnt == CNT_MAX));
  end

  assign busy_o = r_busy;

endmodule

// File: rtl/issue_ctrl.sv
// Issue controller: single-entry decode slot, branch bubbles, load-use blocking, illegal halt.
module issue_ctrl #(
  parameter int unsigned RFADDR    = imhotep_pkg::RFADDR,
  parameter int unsigned MAX_LOADS = imhotep_pkg::MAX_LOADS
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       if_valid_i,
  output logic                       if_ready_o,
  input  logic                       dec_stall_i,
  input  logic                       dec_err_i,
  input  logic [RFADDR-1:0]          dec_r1_addr_i,
  input  logic [RFADDR-1:0]          dec_r2_addr_i,
  input  logic [RFADDR-1:0]          dec_rd_addr_i,
  input  logic                       dec_is_load_i,
  output logic                       ex_valid_o,
  input  logic                       ex_ready_i,
  input  logic                       br_resolve_i,
  input  logic                       br_taken_i,
  input  logic                       lsu_wb_valid_i,
  input  logic [RFADDR-1:0]          lsu_wb_addr_i,
  output logic                       flush_o,
  output logic                       halt_o,
  output logic [(1 << RFADDR)-1:0]   busy_o
);

  import imhotep_pkg::*;

  issue_state_e r_state;
  logic         r_slot;

  logic w_run;
  logic w_hazard;
  logic w_issue;
  logic w_fill;
  logic w_ld_set;

  reg_scoreboard #(
    .RFADDR    (RFADDR),
    .MAX_LOADS (MAX_LOADS)
  ) u_sb (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .set_i      (w_ld_set),
    .set_addr_i (dec_rd_addr_i),
    .clr_i      (lsu_wb_valid_i),
    .clr_addr_i (lsu_wb_addr_i),
    .r1_addr_i  (dec_r1_addr_i),
    .r2_addr_i  (dec_r2_addr_i),
    .rd_addr_i  (dec_rd_addr_i),
    .is_load_i  (dec_is_load_i),
    .hazard_o   (w_hazard),
    .busy_o     (busy_o)
  );

  // Handshakes decoded from registered state and the slot's decode fields
  assign w_run      = (r_state == RUN);
  assign ex_valid_o = w_run & r_slot & ~dec_err_i & ~w_hazard;
  assign w_issue    = ex_valid_o & ex_ready_i;
  assign if_ready_o = w_run & (~r_slot | w_issue);
  assign w_fill     = if_valid_i & if_ready_o;
  assign w_ld_set   = w_issue & dec_is_load_i;
  assign flush_o    = (r_state == WAIT_BR) & br_resolve_i & br_taken_i;
  assign halt_o     = (r_state == HALT);

  // Control FSM and slot occupancy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= RUN;
      r_slot  <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (r_slot && dec_err_i) begin
            r_state <= HALT;
          end else begin
            if (w_issue && dec_stall_i) r_state <= WAIT_BR;
            if (w_fill)                 r_slot  <= 1'b1;
            else if (w_issue)           r_slot  <= 1'b0;
          end
        end
        WAIT_BR: begin
          if (br_resolve_i) begin
            r_state <= RUN;
            if (br_taken_i) r_slot <= 1'b0;
          end
        end
        HALT:    r_state <= HALT;
        default: r_state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_issue_ctrl.sv
// Randomized self-checking bench for issue_ctrl against a cycle-level reference model.
module tb_issue_ctrl;

  localparam int unsigned RFADDR = 5;
  localparam int          NREG   = 32;
  localparam int          MAXL   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_valid;
  logic              if_ready;
  logic              dec_stall;
  logic              dec_err;
  logic [RFADDR-1:0] dec_r1;
  logic [RFADDR-1:0] dec_r2;
  logic [RFADDR-1:0] dec_rd;
  logic              dec_ld;
  logic              ex_valid;
  logic              ex_ready;
  logic              br_resolve;
  logic              br_taken;
  logic              wb_valid;
  logic [RFADDR-1:0] wb_addr;
  logic              flush;
  logic              halt;
  logic [NREG-1:0]   busy;

  always #5 clk = ~clk;

  issue_ctrl #(.RFADDR(RFADDR), .MAX_LOADS(MAXL)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .if_valid_i     (if_valid),
    .if_ready_o     (if_ready),
    .dec_stall_i    (dec_stall),
    .dec_err_i      (dec_err),
    .dec_r1_addr_i  (dec_r1),
    .dec_r2_addr_i  (dec_r2),
    .dec_rd_addr_i  (dec_rd),
    .dec_is_load_i  (dec_ld),
    .ex_valid_o     (ex_valid),
    .ex_ready_i     (ex_ready),
    .br_resolve_i   (br_resolve),
    .br_taken_i     (br_taken),
    .lsu_wb_valid_i (wb_valid),
    .lsu_wb_addr_i  (wb_addr),
    .flush_o        (flush),
    .halt_o         (halt),
    .busy_o         (busy)
  );

  typedef struct packed {
    logic       ld;
    logic       st;
    logic       er;
    logic [4:0] r1;
    logic [4:0] r2;
    logic [4:0] rd;
  } ins_t;

  // Reference model: mode 0 = running, 1 = waiting on a branch, 2 = halted
  ins_t          prog[$];
  int            inflight[$];
  int            m_mode;
  bit            m_slot;
  ins_t          m_ins;
  bit [NREG-1:0] m_busy;
  int            m_cnt;

  int p_valid, p_ready, p_wb, p_res, p_taken, p_stray;
  int n_vec = 0;
  int n_err = 0;
  int n_iss;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ins_t mk(input bit ld, input bit st, input bit er,
                              input int r1, input int r2, input int rd);
    ins_t i;
    i.ld = ld; i.st = st; i.er = er;
    i.r1 = 5'(r1); i.r2 = 5'(r2); i.rd = 5'(rd);
    return i;
  endfunction

  function automatic bit roll(input int pct);
    return $urandom_range(99) < pct;
  endfunction

  function automatic ins_t rand_ins();
    bit ld = roll(30);
    bit st = !ld && roll(12);
    int rd = ld ? int'($urandom_range(7, 1)) : (st ? 0 : int'($urandom_range(7)));
    return mk(ld, st, 1'b0, $urandom_range(7), $urandom_range(7), rd);
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_slot = 0; m_ins = '0; m_busy = '0; m_cnt = 0;
    inflight.delete();
  endfunction

  task automatic knobs(input int v, input int r, input int w, input int res, input int tk);
    p_valid = v; p_ready = r; p_wb = w; p_res = res; p_taken = tk;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; if_valid = 0; ex_ready = 0; br_resolve = 0; br_taken = 0; wb_valid = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    prog.delete();
    #1;
    chk("rst_if_ready", 64'(if_ready), 64'd1);
    chk("rst_ex_valid", 64'(ex_valid), 64'd0);
    chk("rst_flush",    64'(flush),    64'd0);
    chk("rst_halt",     64'(halt),     64'd0);
    chk("rst_busy",     64'(busy),     64'd0);
  endtask

  // One clock: drive, compare against the model, advance the model
  task automatic step();
    bit haz, e_ex, e_rdy, e_flush, issue, fill, wb, res, tk, set;
    int wb_reg, idx;
    if (!(prog.size() > 0)) if_valid = 0;
    if_valid   = (prog.size() > 0) && roll(p_valid);
    ex_ready   = roll(p_ready);
    wb = 0; wb_reg = 0;
    if (inflight.size() > 0 && roll(p_wb)) begin
      idx    = $urandom_range(inflight.size() - 1);
      wb_reg = inflight[idx];
      inflight.delete(idx);
      wb     = 1;
    end
    res = 0; tk = 0;
    if (m_mode == 1 && roll(p_res)) begin
      res = 1; tk = roll(p_taken);
    end else if (m_mode != 1 && !(m_slot && m_ins.st) && roll(p_stray)) begin
      res = 1; tk = roll(50);
    end
    br_resolve = res; br_taken = tk;
    wb_valid   = wb;  wb_addr  = 5'(wb_reg);
    dec_stall  = m_slot ? m_ins.st : 1'b0;
    dec_err    = m_slot ? m_ins.er : 1'b0;
    dec_ld     = m_slot ? m_ins.ld : 1'b0;
    dec_r1     = m_slot ? m_ins.r1 : '0;
    dec_r2     = m_slot ? m_ins.r2 : '0;
    dec_rd     = m_slot ? m_ins.rd : '0;
    #1;
    haz = (m_ins.r1 != 0 && m_busy[m_ins.r1]) || (m_ins.r2 != 0 && m_busy[m_ins.r2]) ||
          (m_ins.rd != 0 && m_busy[m_ins.rd]) || (m_ins.ld && m_cnt == MAXL);
    e_ex    = (m_mode == 0) && m_slot && !m_ins.er && !haz;
    issue   = e_ex && ex_ready;
    e_rdy   = (m_mode == 0) && (!m_slot || issue);
    e_flush = (m_mode == 1) && res && tk;
    fill    = if_valid && e_rdy;
    chk("ex_valid", 64'(ex_valid), 64'(e_ex));
    chk("if_ready", 64'(if_ready), 64'(e_rdy));
    chk("flush",    64'(flush),    64'(e_flush));
    chk("halt",     64'(halt),     64'(m_mode == 2));
    chk("busy",     64'(busy),     64'(m_busy));
    if (ex_valid && ex_ready) n_iss++;
    set = issue && m_ins.ld && m_ins.rd != 0;
    if (wb && m_cnt > 0) begin m_busy[wb_reg] = 0; m_cnt--; end
    if (set) begin m_busy[m_ins.rd] = 1; m_cnt++; inflight.push_back(int'(m_ins.rd)); end
    case (m_mode)
      0: if (m_slot && m_ins.er) m_mode = 2;
         else begin
           if (issue && m_ins.st) m_mode = 1;
           if (fill) begin m_slot = 1; m_ins = prog.pop_front(); end
           else if (issue) begin m_slot = 0; m_ins = '0; end
         end
      1: if (res) begin m_mode = 0; if (tk) begin m_slot = 0; m_ins = '0; end end
      default: ;
    endcase
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1; if_valid = 0; ex_ready = 0; br_resolve = 0; br_taken = 0;
    wb_valid = 0; wb_addr = '0; dec_stall = 0; dec_err = 0; dec_ld = 0;
    dec_r1 = '0; dec_r2 = '0; dec_rd = '0;
    p_stray = 0;
    model_reset();

    // Back-to-back dependent ALU ops issue on consecutive cycles
    do_reset();
    knobs(100, 100, 0, 0, 0);
    prog.push_back(mk(0, 0, 0, 1, 2, 3));
    prog.push_back(mk(0, 0, 0, 3, 0, 4));
    n_iss = 0;
    run(4);
    chk("alu_issue_cnt", 64'(n_iss), 64'd2);

    // Load-use: ADD x6,x5 waits for the x5 writeback
    do_reset();
    knobs(100, 100, 0, 0, 0);
    prog.push_back(mk(1, 0, 0, 1, 0, 5));
    prog.push_back(mk(0, 0, 0, 5, 0, 6));
    run(5);
    knobs(100, 100, 100, 0, 0);
    run(3);

    // Third load held by the in-flight limit
    do_reset();
    knobs(100, 100, 0, 0, 0);
    prog.push_back(mk(1, 0, 0, 1, 0, 7));
    prog.push_back(mk(1, 0, 0, 1, 0, 8));
    prog.push_back(mk(1, 0, 0, 1, 0, 9));
    run(5);
    knobs(100, 100, 100, 0, 0);
    run(5);

    // Branch taken then not taken
    for (int t = 1; t >= 0; t--) begin
      do_reset();
      knobs(100, 100, 0, 0, 0);
      prog.push_back(mk(0, 1, 0, 1, 2, 0));
      prog.push_back(mk(0, 0, 0, 1, 2, 10));
      prog.push_back(mk(0, 0, 0, 1, 2, 11));
      run(5);
      knobs(100, 100, 0, 100, t * 100);
      run(1);
      knobs(100, 100, 0, 0, 0);
      run(4);
    end

    // Illegal instruction halts until reset
    do_reset();
    knobs(100, 100, 0, 0, 0);
    prog.push_back(mk(0, 0, 1, 0, 0, 0));
    prog.push_back(mk(0, 0, 0, 1, 2, 3));
    run(6);
    do_reset();
    run(2);

    // Random traffic
    do_reset();
    p_stray = 3;
    for (int c = 0; c < 3000; c++) begin
      while (prog.size() < 3) prog.push_back(rand_ins());
      knobs(80, 70, 35, 40, 50);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
